// File: rtl/pin_pkg.sv
// Shared types and key constants for the PIN entry controller.
package pin_pkg;

    // Controller operating states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_UNLOCKED = 3'd3,
        ST_PROGRAM  = 3'd4,
        ST_LOCKOUT  = 3'd5
    } pin_state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_PROG  = 4'hE;

    // True for the numeric keys 0-9.
    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

endpackage

// File: rtl/pin_entry_controller_if.sv
// Keypad scanner side and status outputs of the PIN entry controller.
interface pin_entry_controller_if;
    logic [3:0] digit;
    logic       valid;
    logic       unlocked;
    logic       lockout;
    logic       ok_pulse;
    logic       fail_pulse;
    logic [3:0] entry_count;
    logic [3:0] fail_count;

    modport master (
        output digit, valid,
        input  unlocked, lockout, ok_pulse, fail_pulse, entry_count, fail_count
    );

    modport slave (
        input  digit, valid,
        output unlocked, lockout, ok_pulse, fail_pulse, entry_count, fail_count
    );
endinterface

// File: rtl/pin_entry_controller_key_event.sv
// Key debounce/arming: one accept per key press, re-armed only after the
// scanner's valid has been low for RELEASE_CYCLES consecutive cycles.
module key_event #(
    parameter int RELEASE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    output logic accept
);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);

    logic          r_armed;
    logic [RW-1:0] r_rel_cnt;

    // Accept must act on the same edge that samples valid, so it is a gate
    // of the armed register and the live input.
    assign accept = r_armed & valid;

    // Track arming: any high sample disarms and restarts the release count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed   <= 1'b0;
            r_rel_cnt <= '0;
        end else if (valid) begin
            r_armed   <= 1'b0;
            r_rel_cnt <= '0;
        end else if (!r_armed) begin
            if (r_rel_cnt == RW'(RELEASE_CYCLES - 1)) begin
                r_armed   <= 1'b1;
                r_rel_cnt <= '0;
            end else begin
                r_rel_cnt <= r_rel_cnt + RW'(1);
            end
        end else begin
            r_armed   <= 1'b1;
            r_rel_cnt <= '0;
        end
    end
endmodule

// File: rtl/pin_entry_controller.sv
// PIN entry controller: buffers keypad digits, checks them against a stored
// code, handles unlock/relock, code programming, timeouts and lockout.
module pin_entry_controller
    import pin_pkg::*;
#(
    parameter int          CODE_LEN       = 4,
    parameter int          MAX_TRIES      = 3,
    parameter int          RELEASE_CYCLES = 16,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          LOCKOUT_CYCLES = 5000000,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234
) (
    input  logic                    clk,
    input  logic                    reset,
    pin_entry_controller_if.slave   bus
);
    localparam int BW = 4 * CODE_LEN;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    pin_state_t     r_state;
    logic [BW-1:0]  r_code;
    logic [BW-1:0]  r_buf;
    logic [3:0]     r_count;
    logic [3:0]     r_fails;
    logic [TW-1:0]  r_timer;
    logic [LW-1:0]  r_lock_timer;
    logic           r_unlocked;
    logic           r_lockout;
    logic           r_ok;
    logic           r_fail;

    logic           w_accept;
    logic [3:0]     w_key;
    logic           w_is_digit;
    logic           w_full;
    logic [BW-1:0]  w_shifted;
    logic           w_match;
    logic [3:0]     w_fails_inc;
    logic           w_timeout;
    logic           w_lock_done;

    key_event #(.RELEASE_CYCLES(RELEASE_CYCLES)) u_key_event (
        .clk    (clk),
        .reset  (reset),
        .valid  (bus.valid),
        .accept (w_accept)
    );

    assign w_key       = bus.digit;
    assign w_is_digit  = is_digit(w_key);
    assign w_full      = (r_count >= 4'(CODE_LEN));
    assign w_shifted   = (r_buf << 3'd4) | BW'(w_key);
    assign w_match     = (r_count == 4'(CODE_LEN)) && (r_buf == r_code);
    assign w_fails_inc = (r_fails >= 4'(MAX_TRIES)) ? r_fails : (r_fails + 4'd1);
    assign w_timeout   = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_lock_done = (r_lock_timer == LW'(LOCKOUT_CYCLES - 1));

    assign bus.unlocked    = r_unlocked;
    assign bus.lockout     = r_lockout;
    assign bus.ok_pulse    = r_ok;
    assign bus.fail_pulse  = r_fail;
    assign bus.entry_count = r_count;
    assign bus.fail_count  = r_fails;

    // Main state machine; status outputs are updated on the same edge as the
    // transition that changes them, so they are all plain registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_code       <= DEFAULT_CODE[BW-1:0];
            r_buf        <= '0;
            r_count      <= 4'd0;
            r_fails      <= 4'd0;
            r_timer      <= '0;
            r_lock_timer <= '0;
            r_unlocked   <= 1'b0;
            r_lockout    <= 1'b0;
            r_ok         <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_ok   <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (w_accept && w_is_digit) begin
                        r_buf   <= BW'(w_key);
                        r_count <= 4'd1;
                        r_state <= ST_ENTRY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_ENTRY: begin
                    if (w_accept) begin
                        r_timer <= '0;
                        if (w_is_digit) begin
                            if (!w_full) begin
                                r_buf   <= w_shifted;
                                r_count <= r_count + 4'd1;
                            end else begin
                                r_count <= r_count;
                            end
                        end else if (w_key == KEY_CLEAR) begin
                            r_buf   <= '0;
                            r_count <= 4'd0;
                            r_state <= ST_IDLE;
                        end else if (w_key == KEY_ENTER) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_ENTRY;
                        end
                    end else if (w_timeout) begin
                        r_timer <= '0;
                        r_buf   <= '0;
                        r_count <= 4'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                ST_CHECK: begin
                    r_timer <= '0;
                    r_buf   <= '0;
                    r_count <= 4'd0;
                    if (w_match) begin
                        r_ok       <= 1'b1;
                        r_fails    <= 4'd0;
                        r_unlocked <= 1'b1;
                        r_state    <= ST_UNLOCKED;
                    end else begin
                        r_fail  <= 1'b1;
                        r_fails <= w_fails_inc;
                        if (w_fails_inc == 4'(MAX_TRIES)) begin
                            r_lockout    <= 1'b1;
                            r_lock_timer <= '0;
                            r_state      <= ST_LOCKOUT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_UNLOCKED: begin
                    if (w_accept) begin
                        r_timer <= '0;
                        if ((w_key == KEY_ENTER) || (w_key == KEY_CLEAR)) begin
                            r_unlocked <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else if (w_key == KEY_PROG) begin
                            r_buf   <= '0;
                            r_count <= 4'd0;
                            r_state <= ST_PROGRAM;
                        end else begin
                            r_state <= ST_UNLOCKED;
                        end
                    end else if (w_timeout) begin
                        r_timer    <= '0;
                        r_unlocked <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                ST_PROGRAM: begin
                    if (w_accept) begin
                        r_timer <= '0;
                        if (w_is_digit) begin
                            if (!w_full) begin
                                r_buf   <= w_shifted;
                                r_count <= r_count + 4'd1;
                            end else begin
                                r_count <= r_count;
                            end
                        end else if ((w_key == KEY_ENTER) || (w_key == KEY_CLEAR)) begin
                            // Only a complete code on enter replaces the stored one.
                            if ((w_key == KEY_ENTER) && w_full) begin
                                r_code <= r_buf;
                            end else begin
                                r_code <= r_code;
                            end
                            r_buf   <= '0;
                            r_count <= 4'd0;
                            r_state <= ST_UNLOCKED;
                        end else begin
                            r_state <= ST_PROGRAM;
                        end
                    end else if (w_timeout) begin
                        r_timer    <= '0;
                        r_buf      <= '0;
                        r_count    <= 4'd0;
                        r_unlocked <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                ST_LOCKOUT: begin
                    r_timer <= '0;
                    if (w_lock_done) begin
                        r_lock_timer <= '0;
                        r_lockout    <= 1'b0;
                        r_fails      <= 4'd0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_lock_timer <= r_lock_timer + LW'(1);
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_buf        <= '0;
                    r_count      <= 4'd0;
                    r_timer      <= '0;
                    r_lock_timer <= '0;
                    r_unlocked   <= 1'b0;
                    r_lockout    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pin_entry_controller.sv
// Self-checking bench for pin_entry_controller with a queue-based reference model.
module tb_pin_entry_controller;
    import pin_pkg::*;

    typedef enum int {M_IDLE, M_ENTRY, M_CHECK, M_OPEN, M_PROG, M_LOCK} mmode_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pin_entry_controller_if bus();

    pin_entry_controller #(
        .CODE_LEN(4), .MAX_TRIES(3), .RELEASE_CYCLES(2),
        .TIMEOUT_CYCLES(50), .LOCKOUT_CYCLES(20), .DEFAULT_CODE(32'h0000_1234)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_diff   = 0;
    int dut_ok_seen = 0, dut_fail_seen = 0, dut_lock_cycles = 0;

    // Reference model state (behavioural, in terms of keys and digit lists).
    mmode_t m_mode = M_IDLE;
    int     m_q[$];
    int     m_code[$];
    bit     m_armed = 1'b0;
    int     m_quiet = 0;
    int     m_idle = 0, m_lock = 0, m_fails = 0;
    bit     m_ok = 1'b0, m_fail = 1'b0;

    function automatic bit codes_equal();
        if (m_q.size() != m_code.size()) return 1'b0;
        foreach (m_q[i]) if (m_q[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input logic rst, input logic v, input logic [3:0] d);
        bit acc;
        int k;
        m_ok = 1'b0;
        m_fail = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_q.delete(); m_code.delete();
            m_code.push_back(1); m_code.push_back(2); m_code.push_back(3); m_code.push_back(4);
            m_armed = 1'b0; m_quiet = 0; m_idle = 0; m_lock = 0; m_fails = 0;
            return;
        end
        acc = m_armed && v;
        if (v) begin
            m_armed = 1'b0; m_quiet = 0;
        end else if (!m_armed) begin
            m_quiet++;
            if (m_quiet == 2) begin m_armed = 1'b1; m_quiet = 0; end
        end
        k = int'(d);
        case (m_mode)
            M_IDLE: if (acc && k <= 9) begin m_q.delete(); m_q.push_back(k); m_mode = M_ENTRY; m_idle = 0; end
            M_ENTRY, M_PROG: begin
                if (acc) begin
                    m_idle = 0;
                    if (k <= 9) begin
                        if (m_q.size() < 4) m_q.push_back(k);
                    end else if (m_mode == M_ENTRY && k == 12) begin
                        m_q.delete(); m_mode = M_IDLE;
                    end else if (m_mode == M_ENTRY && k == 10) begin
                        m_mode = M_CHECK;
                    end else if (m_mode == M_PROG && (k == 10 || k == 12)) begin
                        if (k == 10 && m_q.size() == 4) m_code = m_q;
                        m_q.delete(); m_mode = M_OPEN;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == 50) begin m_q.delete(); m_mode = M_IDLE; m_idle = 0; end
                end
            end
            M_CHECK: begin
                m_idle = 0;
                if (codes_equal()) begin
                    m_ok = 1'b1; m_fails = 0; m_mode = M_OPEN;
                end else begin
                    m_fail = 1'b1;
                    m_fails = (m_fails + 1 > 3) ? 3 : m_fails + 1;
                    if (m_fails == 3) begin m_mode = M_LOCK; m_lock = 0; end
                    else m_mode = M_IDLE;
                end
                m_q.delete();
            end
            M_OPEN: begin
                if (acc) begin
                    m_idle = 0;
                    if (k == 10 || k == 12) m_mode = M_IDLE;
                    else if (k == 14) begin m_q.delete(); m_mode = M_PROG; end
                end else begin
                    m_idle++;
                    if (m_idle == 50) begin m_mode = M_IDLE; m_idle = 0; end
                end
            end
            M_LOCK: begin
                m_lock++;
                if (m_lock == 20) begin m_mode = M_IDLE; m_fails = 0; m_lock = 0; end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // One clock: drive inputs, advance the model, tally any cycle where the
    // DUT's outputs diverge from the model.
    task automatic step(input logic v, input logic [3:0] d, input logic rst);
        bit e_ul, e_lo;
        reset = rst; bus.valid = v; bus.digit = d;
        @(posedge clk);
        model_edge(rst, v, d);
        #1;
        e_ul = (m_mode == M_OPEN) || (m_mode == M_PROG);
        e_lo = (m_mode == M_LOCK);
        if (bus.unlocked !== e_ul || bus.lockout !== e_lo || bus.ok_pulse !== m_ok ||
            bus.fail_pulse !== m_fail || bus.entry_count !== 4'(m_q.size()) ||
            bus.fail_count !== 4'(m_fails)) begin
            n_diff++;
            if (n_diff <= 5)
                $display("diverge t=%0t dut ul=%b lo=%b ok=%b fl=%b ec=%0d fc=%0d model ul=%b lo=%b ok=%b fl=%b ec=%0d fc=%0d",
                         $time, bus.unlocked, bus.lockout, bus.ok_pulse, bus.fail_pulse, bus.entry_count,
                         bus.fail_count, e_ul, e_lo, m_ok, m_fail, m_q.size(), m_fails);
        end
        dut_ok_seen     += int'(bus.ok_pulse);
        dut_fail_seen   += int'(bus.fail_pulse);
        dut_lock_cycles += int'(bus.lockout);
    endtask

    task automatic press(input logic [3:0] k);
        step(1'b1, k, 1'b0);
        repeat (3) step(1'b0, k, 1'b0);
    endtask

    task automatic press_seq(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic test_reset();
        int d0;
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        d0 = n_diff;
        n_checks++; if (bus.unlocked !== 1'b0 || bus.lockout !== 1'b0) $display("FAIL reset_flags: got ul=%b lo=%b expected 0 0", bus.unlocked, bus.lockout); else n_pass++;
        n_checks++; if (bus.ok_pulse !== 1'b0 || bus.fail_pulse !== 1'b0) $display("FAIL reset_pulses: got ok=%b fl=%b expected 0 0", bus.ok_pulse, bus.fail_pulse); else n_pass++;
        n_checks++; if (bus.entry_count !== 4'd0 || bus.fail_count !== 4'd0) $display("FAIL reset_counts: got ec=%0d fc=%0d expected 0 0", bus.entry_count, bus.fail_count); else n_pass++;
        step(1'b1, 4'd7, 1'b1);
        repeat (3) step(1'b1, 4'd7, 1'b0);
        n_checks++; if (bus.entry_count !== 4'd0) $display("FAIL key_held_through_reset: got ec=%0d expected 0", bus.entry_count); else n_pass++;
        repeat (3) step(1'b0, 4'd0, 1'b0);
        n_checks++; if (n_diff !== d0) $display("FAIL reset_model_trace: got %0d diverging cycles expected 0", n_diff - d0); else n_pass++;
    endtask

    task automatic test_unlock();
        int d0 = n_diff, ok0 = dut_ok_seen;
        press_seq(4'd1, 4'd2, 4'd3, 4'd4);
        n_checks++; if (bus.entry_count !== 4'd4) $display("FAIL unlock_entry_count: got %0d expected 4", bus.entry_count); else n_pass++;
        step(1'b1, KEY_ENTER, 1'b0);
        n_checks++; if (bus.unlocked !== 1'b0) $display("FAIL unlock_during_check: got %b expected 0", bus.unlocked); else n_pass++;
        step(1'b0, KEY_ENTER, 1'b0);
        n_checks++; if (bus.unlocked !== 1'b1 || bus.ok_pulse !== 1'b1) $display("FAIL unlock_after_check: got ul=%b ok=%b expected 1 1", bus.unlocked, bus.ok_pulse); else n_pass++;
        repeat (2) step(1'b0, 4'd0, 1'b0);
        n_checks++; if (dut_ok_seen - ok0 !== 1) $display("FAIL unlock_ok_pulses: got %0d expected 1", dut_ok_seen - ok0); else n_pass++;
        n_checks++; if (bus.fail_count !== 4'd0) $display("FAIL unlock_fail_count: got %0d expected 0", bus.fail_count); else n_pass++;
        press(KEY_ENTER);
        n_checks++; if (bus.unlocked !== 1'b0) $display("FAIL relock: got %b expected 0", bus.unlocked); else n_pass++;
        n_checks++; if (n_diff !== d0) $display("FAIL unlock_model_trace: got %0d diverging cycles expected 0", n_diff - d0); else n_pass++;
    endtask

    task automatic test_lockout();
        int d0 = n_diff, f0 = dut_fail_seen, l0 = dut_lock_cycles;
        for (int i = 1; i <= 3; i++) begin
            press_seq(4'd1, 4'd2, 4'd3, 4'd5);
            press(KEY_ENTER);
            n_checks++; if (bus.fail_count !== 4'(i)) $display("FAIL lockout_fail_count_%0d: got %0d expected %0d", i, bus.fail_count, i); else n_pass++;
        end
        n_checks++; if (bus.lockout !== 1'b1) $display("FAIL lockout_asserted: got %b expected 1", bus.lockout); else n_pass++;
        repeat (4) press(4'd1);
        repeat (6) step(1'b0, 4'd0, 1'b0);
        n_checks++; if (dut_lock_cycles - l0 !== 20) $display("FAIL lockout_length: got %0d expected 20", dut_lock_cycles - l0); else n_pass++;
        n_checks++; if (dut_fail_seen - f0 !== 3) $display("FAIL lockout_fail_pulses: got %0d expected 3", dut_fail_seen - f0); else n_pass++;
        n_checks++; if (bus.lockout !== 1'b0 || bus.fail_count !== 4'd0 || bus.entry_count !== 4'd0)
            $display("FAIL lockout_exit: got lo=%b fc=%0d ec=%0d expected 0 0 0", bus.lockout, bus.fail_count, bus.entry_count); else n_pass++;
        n_checks++; if (n_diff !== d0) $display("FAIL lockout_model_trace: got %0d diverging cycles expected 0", n_diff - d0); else n_pass++;
    endtask

    task automatic test_hold_chatter();
        int d0 = n_diff;
        repeat (10) step(1'b1, 4'd7, 1'b0);
        n_checks++; if (bus.entry_count !== 4'd1) $display("FAIL held_key: got ec=%0d expected 1", bus.entry_count); else n_pass++;
        repeat (3) step(1'b0, 4'd7, 1'b0);
        step(1'b1, 4'd7, 1'b0); step(1'b0, 4'd7, 1'b0); step(1'b1, 4'd7, 1'b0);
        repeat (3) step(1'b0, 4'd7, 1'b0);
        n_checks++; if (bus.entry_count !== 4'd2) $display("FAIL chatter_single_accept: got ec=%0d expected 2", bus.entry_count); else n_pass++;
        press(KEY_CLEAR);
        n_checks++; if (bus.entry_count !== 4'd0) $display("FAIL clear_entry: got ec=%0d expected 0", bus.entry_count); else n_pass++;
        n_checks++; if (n_diff !== d0) $display("FAIL chatter_model_trace: got %0d diverging cycles expected 0", n_diff - d0); else n_pass++;
    endtask

    task automatic test_program();
        int d0 = n_diff, f0;
        press_seq(4'd1, 4'd2, 4'd3, 4'd4); press(KEY_ENTER);
        n_checks++; if (bus.unlocked !== 1'b1) $display("FAIL prog_initial_unlock: got %b expected 1", bus.unlocked); else n_pass++;
        press(KEY_PROG);
        press_seq(4'd9, 4'd8, 4'd7, 4'd6);
        n_checks++; if (bus.entry_count !== 4'd4 || bus.unlocked !== 1'b1) $display("FAIL prog_buffer: got ec=%0d ul=%b expected 4 1", bus.entry_count, bus.unlocked); else n_pass++;
        press(KEY_ENTER);
        press(KEY_CLEAR);
        n_checks++; if (bus.unlocked !== 1'b0) $display("FAIL prog_relock: got %b expected 0", bus.unlocked); else n_pass++;
        press_seq(4'd9, 4'd8, 4'd7, 4'd6); press(KEY_ENTER);
        n_checks++; if (bus.unlocked !== 1'b1) $display("FAIL new_code_unlock: got %b expected 1", bus.unlocked); else n_pass++;
        press(KEY_ENTER);
        f0 = dut_fail_seen;
        press_seq(4'd1, 4'd2, 4'd3, 4'd4); press(KEY_ENTER);
        n_checks++; if (dut_fail_seen - f0 !== 1 || bus.fail_count !== 4'd1 || bus.unlocked !== 1'b0)
            $display("FAIL old_code_rejected: got pulses=%0d fc=%0d ul=%b expected 1 1 0", dut_fail_seen - f0, bus.fail_count, bus.unlocked); else n_pass++;
        n_checks++; if (n_diff !== d0) $display("FAIL prog_model_trace: got %0d diverging cycles expected 0", n_diff - d0); else n_pass++;
    endtask

    task automatic test_timeout_reset();
        int d0 = n_diff;
        press(4'd1); press(4'd2);
        repeat (40) step(1'b0, 4'd0, 1'b0);
        n_checks++; if (bus.entry_count !== 4'd2) $display("FAIL before_timeout: got ec=%0d expected 2", bus.entry_count); else n_pass++;
        repeat (20) step(1'b0, 4'd0, 1'b0);
        n_checks++; if (bus.entry_count !== 4'd0 || bus.fail_count !== 4'd1) $display("FAIL after_timeout: got ec=%0d fc=%0d expected 0 1", bus.entry_count, bus.fail_count); else n_pass++;
        press(4'd1); press(4'd2);
        step(1'b0, 4'd0, 1'b1);
        n_checks++; if ({bus.unlocked, bus.lockout, bus.ok_pulse, bus.fail_pulse, bus.entry_count, bus.fail_count} !== 12'd0)
            $display("FAIL midentry_reset: got ec=%0d fc=%0d ul=%b expected all zero", bus.entry_count, bus.fail_count, bus.unlocked); else n_pass++;
        repeat (3) step(1'b0, 4'd0, 1'b0);
        press_seq(4'd1, 4'd2, 4'd3, 4'd4); press(KEY_ENTER);
        n_checks++; if (bus.unlocked !== 1'b1) $display("FAIL default_code_restored: got %b expected 1", bus.unlocked); else n_pass++;
        press(KEY_CLEAR);
        n_checks++; if (n_diff !== d0) $display("FAIL timeout_model_trace: got %0d diverging cycles expected 0", n_diff - d0); else n_pass++;
    endtask

    task automatic test_random();
        int d0 = n_diff;
        logic [3:0] keys [10];
        logic [3:0] k;
        logic v, r;
        keys = '{4'd1, 4'd2, 4'd3, 4'd4, KEY_ENTER, KEY_CLEAR, KEY_PROG, 4'd9, 4'hB, 4'd5};
        for (int c = 0; c < 1200; c++) begin
            v = ($urandom_range(0, 99) < 35);
            k = keys[$urandom_range(0, 9)];
            r = ($urandom_range(0, 399) == 0);
            step(v, k, r);
            if (c % 100 == 99) begin
                n_checks++; if (bus.entry_count !== 4'(m_q.size()) || bus.fail_count !== 4'(m_fails))
                    $display("FAIL random_counts_%0d: got ec=%0d fc=%0d expected %0d %0d", c, bus.entry_count, bus.fail_count, m_q.size(), m_fails); else n_pass++;
            end
        end
        n_checks++; if (n_diff !== d0) $display("FAIL random_model_trace: got %0d diverging cycles expected 0", n_diff - d0); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        bus.valid = 1'b0;
        bus.digit = 4'd0;
        test_reset();
        test_unlock();
        test_lockout();
        test_hold_chatter();
        test_program();
        test_timeout_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pin_entry_controller.md
PIN_ENTRY_CONTROLLER -- requirements
Module: pin_entry_controller

Interface
REQ-001 Parameter CODE_LEN, 4, number of digits in a code (1..8).
REQ-002 Parameter MAX_TRIES, 3, consecutive failed checks that trigger lockout.
REQ-003 Parameter RELEASE_CYCLES, 16, consecutive cycles with valid low before the next key is accepted.
REQ-004 Parameter TIMEOUT_CYCLES, 1000000, idle cycles (no accepted key) before abandoning ENTRY/PROGRAM or relocking UNLOCKED.
REQ-005 Parameter LOCKOUT_CYCLES, 5000000, length of the lockout period.
REQ-006 Parameter DEFAULT_CODE, 32'h0000_1234, code loaded at reset; the low CODE_LEN nibbles are used, most significant nibble = first digit.
REQ-007 clk  input  1  single system clock; all state changes on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 digit  input  4  key code from the keypad scanner (0-9 digits, A enter, C clear, E program).
REQ-010 valid  input  1  level from the scanner, high while a key is detected.
REQ-011 unlocked  output  1  high while in UNLOCKED or PROGRAM.
REQ-012 lockout  output  1  high while in LOCKOUT.
REQ-013 ok_pulse  output  1  one-cycle pulse on a successful check.
REQ-014 fail_pulse  output  1  one-cycle pulse on a failed check.
REQ-015 entry_count  output  4  number of digits currently buffered (0..CODE_LEN).
REQ-016 fail_count  output  4  consecutive failed checks (0..MAX_TRIES).

Function
REQ-017 A key SHALL be accepted at the first rising clk edge where valid=1 while armed; acceptance disarms; re-arm requires RELEASE_CYCLES consecutive sampled valid=0 cycles, and any valid=1 restarts that count.
REQ-018 Accepted keys other than 0-9, A, C, E SHALL be ignored in every state.
REQ-019 States SHALL be IDLE, ENTRY, CHECK, UNLOCKED, PROGRAM, LOCKOUT.
REQ-020 IDLE: digit -> buffer=digit, entry_count=1, ENTRY; A, C, E ignored.
REQ-021 ENTRY: digit with entry_count<CODE_LEN shifts into buffer and increments entry_count; digit at entry_count=CODE_LEN ignored; C clears buffer/count -> IDLE; A -> CHECK; E ignored.
REQ-022 CHECK SHALL last exactly one cycle; match iff entry_count=CODE_LEN and buffer equals stored code.
REQ-023 On match: ok_pulse=1 during the CHECK->UNLOCKED edge output cycle, fail_count=0, buffer cleared, -> UNLOCKED.
REQ-024 On mismatch: fail_pulse=1, fail_count+1, buffer cleared; -> LOCKOUT if new fail_count=MAX_TRIES, else IDLE.
REQ-025 Latency: A accepted at edge n -> CHECK after n; unlocked/lockout and pulses valid after edge n+1.
REQ-026 UNLOCKED: A or C -> IDLE (relock); E -> PROGRAM with buffer/count cleared; digits ignored.
REQ-027 PROGRAM: digits buffered as in ENTRY; A with entry_count=CODE_LEN writes buffer to stored code -> UNLOCKED; A with fewer digits discards -> UNLOCKED; C discards -> UNLOCKED.
REQ-028 LOCKOUT: all keys ignored (arming still tracked); after LOCKOUT_CYCLES cycles -> IDLE with fail_count=0.
REQ-029 Timeout counter SHALL restart on every accepted key and on every state entry; expiry in ENTRY -> IDLE (buffer cleared, fail_count unchanged); in UNLOCKED or PROGRAM -> IDLE, stored code unchanged.
REQ-030 Counters SHALL saturate, never wrap; fail_count never exceeds MAX_TRIES.

Reset
REQ-031 Reset SHALL force IDLE, stored code=DEFAULT_CODE, buffer=0, entry_count=0, fail_count=0, all outputs 0, timers 0, disarmed with release count 0.
REQ-032 Reset SHALL override any simultaneous key acceptance or timer expiry; a key held through reset is not accepted until released for RELEASE_CYCLES.

Structure
REQ-033 Package pin_pkg SHALL hold the state enum and key constants KEY_ENTER=4'hA, KEY_CLEAR=4'hC, KEY_PROG=4'hE.
REQ-034 Arming/release logic SHALL be one sub-module key_event (inputs clk, reset, valid; output one-cycle accept).
REQ-035 Timer widths SHALL be derived from parameters via $clog2.

Verification (RELEASE_CYCLES=2, TIMEOUT_CYCLES=50, LOCKOUT_CYCLES=20, defaults otherwise)
REQ-036 Keys 1,2,3,4,A each released 3 cycles -> ok_pulse once, unlocked=1 two edges after A, fail_count=0.
REQ-037 Keys 1,2,3,5,A three times -> fail_pulse x3, fail_count 1,2,3, lockout=1 for 20 cycles, then IDLE, fail_count=0.
REQ-038 valid held high 10 cycles on digit 7 -> entry_count=1 only; chattering valid (1,0,1) within 2 cycles -> single accept.
REQ-039 Unlock, E, 9,8,7,6, A, C, then 9,8,7,6,A -> unlocked again; then 1,2,3,4,A -> fail_pulse.
REQ-040 Keys 1,2 then idle 50 cycles -> IDLE, entry_count=0; reset asserted mid-ENTRY -> all outputs 0, code reverts to 1234.
